// File: rtl/difftest_commit_tracker.sv
// Difftest producer: shadows pc/GPR/CSR state from retiring instructions and pulses
// a post-commit snapshot to the sink. Optional watchdog under DIFFTEST_WATCHDOG_EN.
module difftest_commit_tracker #(
    parameter logic [31:0] RESET_PC       = 32'h8000_0000,
    parameter logic [31:0] MSTATUS_RESET  = 32'h0000_1800,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          commit_valid,
    output logic          commit_ready,
    input  logic [31:0]   commit_next_pc,
    input  logic          commit_is_ebreak,
    input  logic          gpr_wen,
    input  logic [4:0]    gpr_waddr,
    input  logic [31:0]   gpr_wdata,
    input  logic          csr_wen,
    input  logic [2:0]    csr_widx,
    input  logic [31:0]   csr_wdata,
    output logic          diff_enable,
    output logic [31:0]   diff_pc,
    output logic [1023:0] diff_regs,
    output logic [191:0]  diff_csr,
    output logic [63:0]   commit_count,
    output logic          halted,
    output logic          timeout
);

    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0][31:0] regs_q, regs_d;
    logic [5:0][31:0]  csr_q, csr_d;
    logic [63:0]       cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              halted_q, halted_d;
    logic              accept;

`ifdef DIFFTEST_WATCHDOG_EN
    logic [31:0]       wd_q, wd_d;
    logic              timeout_q, timeout_d;
`endif

    assign commit_ready = (state_q == RUN);
    assign accept       = commit_valid && commit_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        regs_d   = regs_q;
        csr_d    = csr_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        en_d     = accept;
        if (accept) begin
            pc_d  = commit_next_pc;
            cnt_d = cnt_q + 64'd1;
            // x0 is never written, so its reset value of zero is what it reads as
            if (gpr_wen && gpr_waddr != 5'd0)
                regs_d[gpr_waddr] = gpr_wdata;
            if (csr_wen && csr_widx <= 3'd5)
                csr_d[csr_widx] = csr_wdata;
            if (commit_is_ebreak) begin
                state_d  = HALTED;
                halted_d = 1'b1;
            end
        end
`ifdef DIFFTEST_WATCHDOG_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (accept) begin
            wd_d = '0;
        end else if (state_q == RUN) begin
            // a stalled core stops the comparison without claiming an ebreak halt
            if (wd_q == TIMEOUT_CYCLES - 1) begin
                timeout_d = 1'b1;
                state_d   = HALTED;
            end else begin
                wd_d = wd_q + 32'd1;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            regs_q    <= '0;
            csr_q     <= {128'd0, MSTATUS_RESET, 32'd0};
            cnt_q     <= '0;
            en_q      <= 1'b0;
            halted_q  <= 1'b0;
`ifdef DIFFTEST_WATCHDOG_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            regs_q    <= regs_d;
            csr_q     <= csr_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            halted_q  <= halted_d;
`ifdef DIFFTEST_WATCHDOG_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign diff_enable  = en_q;
    assign diff_pc      = pc_q;
    assign diff_regs    = regs_q;
    assign diff_csr     = csr_q;
    assign commit_count = cnt_q;
    assign halted       = halted_q;

`ifdef DIFFTEST_WATCHDOG_EN
    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_difftest_commit_tracker.sv
// Bench for difftest_commit_tracker: architectural-state model checked every cycle,
// plus directed literal expectations. Watchdog cases run when DIFFTEST_WATCHDOG_EN is set.
module tb_difftest_commit_tracker;

    localparam int unsigned TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          commit_valid = 1'b0;
    logic          commit_ready;
    logic [31:0]   commit_next_pc = '0;
    logic          commit_is_ebreak = 1'b0;
    logic          gpr_wen = 1'b0;
    logic [4:0]    gpr_waddr = '0;
    logic [31:0]   gpr_wdata = '0;
    logic          csr_wen = 1'b0;
    logic [2:0]    csr_widx = '0;
    logic [31:0]   csr_wdata = '0;
    logic          diff_enable;
    logic [31:0]   diff_pc;
    logic [1023:0] diff_regs;
    logic [191:0]  diff_csr;
    logic [63:0]   commit_count;
    logic          halted;
    logic          timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    difftest_commit_tracker #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_next_pc(commit_next_pc), .commit_is_ebreak(commit_is_ebreak),
        .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
        .csr_wen(csr_wen), .csr_widx(csr_widx), .csr_wdata(csr_wdata),
        .diff_enable(diff_enable), .diff_pc(diff_pc), .diff_regs(diff_regs),
        .diff_csr(diff_csr), .commit_count(commit_count), .halted(halted),
        .timeout(timeout)
    );

    // architectural model
    bit              m_live = 0;
    logic [31:0]     m_pc;
    logic [31:0]     m_gpr [32];
    logic [31:0]     m_csr [6];
    longint unsigned m_cnt;
    bit              m_en, m_halt, m_stop, m_to;
    int              m_idle;

    always @(posedge clock) begin
        if (reset) begin
            m_live = 1;
            m_pc   = 32'h8000_0000;
            foreach (m_gpr[i]) m_gpr[i] = '0;
            foreach (m_csr[i]) m_csr[i] = '0;
            m_csr[1] = 32'h0000_1800;
            m_cnt = 0; m_en = 0; m_halt = 0; m_stop = 0; m_to = 0; m_idle = 0;
        end else if (m_live) begin
            m_en = commit_valid && !m_stop;
            if (m_en) begin
                m_pc = commit_next_pc;
                if (gpr_wen && gpr_waddr != 0) m_gpr[gpr_waddr] = gpr_wdata;
                if (csr_wen && csr_widx < 6) m_csr[csr_widx] = csr_wdata;
                m_cnt++;
                m_idle = 0;
                if (commit_is_ebreak) begin m_halt = 1; m_stop = 1; end
            end
`ifdef DIFFTEST_WATCHDOG_EN
            else if (!m_stop) begin
                m_idle++;
                if (m_idle == TO) begin m_to = 1; m_stop = 1; end
            end
`endif
        end
    end

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // per-cycle compare against the model
    always @(posedge clock) begin
        #1;
        if (m_live) begin
            logic [1023:0] ev;
            logic [191:0]  ec;
            for (int i = 0; i < 32; i++) ev[32*i +: 32] = m_gpr[i];
            for (int j = 0; j < 6; j++)  ec[32*j +: 32] = m_csr[j];
            chk("diff_enable", diff_enable, m_en);
            chk("diff_pc", diff_pc, m_pc);
            chk("diff_csr", diff_csr, ec);
            chk("commit_count", commit_count, m_cnt);
            chk("halted", halted, m_halt);
            chk("timeout", timeout, m_to);
            chk("commit_ready", commit_ready, !m_stop);
            n_tests++;
            if (diff_regs !== ev) begin
                n_fail++;
                for (int i = 0; i < 32; i++)
                    if (diff_regs[32*i +: 32] !== ev[32*i +: 32]) begin
                        $display("FAIL diff_regs x%0d: got %h expected %h", i,
                                 diff_regs[32*i +: 32], ev[32*i +: 32]);
                        break;
                    end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        commit_valid = 0; gpr_wen = 0; csr_wen = 0; commit_is_ebreak = 0;
        repeat (n) tick();
    endtask

    task automatic commit(input logic [31:0] npc, input bit gw, input logic [4:0] ga,
                          input logic [31:0] gd, input bit cw, input logic [2:0] ci,
                          input logic [31:0] cd, input bit eb);
        commit_valid = 1; commit_next_pc = npc; commit_is_ebreak = eb;
        gpr_wen = gw; gpr_waddr = ga; gpr_wdata = gd;
        csr_wen = cw; csr_widx = ci; csr_wdata = cd;
        tick();
    endtask

    initial begin
        // reset, then idle
        reset = 1; idle(2); reset = 0; idle(5);
        chk("rst_enable", diff_enable, 1'b0);
        chk("rst_pc", diff_pc, 32'h8000_0000);
        chk("rst_mstatus", diff_csr[63:32], 32'h0000_1800);
        chk("rst_count", commit_count, 64'd0);
        chk("rst_ready", commit_ready, 1'b1);

        // single commit writing x5
        commit(32'h8000_0004, 1, 5'd5, 32'hDEAD_BEEF, 0, 3'd0, 32'h0, 0);
        chk("c1_enable", diff_enable, 1'b1);
        chk("c1_x5", diff_regs[191:160], 32'hDEAD_BEEF);
        chk("c1_count", commit_count, 64'd1);
        idle(1);
        chk("c1_pulse_end", diff_enable, 1'b0);

        // x0 write dropped, mepc written in same commit
        commit(32'h8000_0008, 1, 5'd0, 32'h0000_1234, 1, 3'd0, 32'h8000_0100, 0);
        chk("x0_zero", diff_regs[31:0], 32'h0);
        chk("mepc", diff_csr[31:0], 32'h8000_0100);

        // out-of-range CSR slot ignored; commit still counts and writes its GPR
        commit(32'h8000_000C, 1, 5'd7, 32'h0000_55AA, 1, 3'd6, 32'hFFFF_FFFF, 0);
        chk("csr6_count", commit_count, 64'd3);
        chk("csr6_enable", diff_enable, 1'b1);
        chk("csr6_slot5", diff_csr[191:160], 32'h0);
        chk("csr6_x7", diff_regs[255:224], 32'h0000_55AA);

        // reset alongside a valid commit discards it
        reset = 1;
        commit(32'h8000_0010, 1, 5'd3, 32'h1, 0, 3'd0, 32'h0, 0);
        reset = 0;
        chk("rst_mid_enable", diff_enable, 1'b0);
        chk("rst_mid_count", commit_count, 64'd0);

        // four back-to-back commits
        for (int i = 0; i < 4; i++) begin
            commit(32'h8000_0000 + 32'(4 * (i + 1)), 1, 5'(i + 1), 32'(i * 32'h1111),
                   1, 3'(i), 32'hC000_0000 + 32'(i), 0);
            chk("b2b_enable", diff_enable, 1'b1);
            chk("b2b_pc", diff_pc, 32'h8000_0000 + 32'(4 * (i + 1)));
        end
        chk("b2b_count", commit_count, 64'd4);
        idle(1);
        chk("b2b_pulse_end", diff_enable, 1'b0);

        // ebreak then further commit attempts
        commit(32'h8000_0020, 0, 5'd0, 32'h0, 0, 3'd0, 32'h0, 1);
        chk("ebreak_enable", diff_enable, 1'b1);
        chk("ebreak_halted", halted, 1'b1);
        chk("ebreak_ready", commit_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            commit(32'h9000_0000, 1, 5'd9, 32'hAAAA_AAAA, 1, 3'd2, 32'hBBBB_BBBB, 0);
            chk("halt_enable", diff_enable, 1'b0);
        end
        chk("halt_count", commit_count, 64'd5);
        chk("halt_pc", diff_pc, 32'h8000_0020);
        idle(1);
        reset = 1; idle(1); reset = 0;
        chk("rerun_pc", diff_pc, 32'h8000_0000);
        chk("rerun_count", commit_count, 64'd0);
        chk("rerun_halted", halted, 1'b0);
        chk("rerun_ready", commit_ready, 1'b1);
        chk("rerun_mstatus", diff_csr[63:32], 32'h0000_1800);
        chk("rerun_x5", diff_regs[191:160], 32'h0);

`ifdef DIFFTEST_WATCHDOG_EN
        idle(7);
        chk("wd_pre", timeout, 1'b0);
        idle(1);
        chk("wd_fire", timeout, 1'b1);
        chk("wd_ready", commit_ready, 1'b0);
        chk("wd_halted", halted, 1'b0);
        reset = 1; idle(1); reset = 0;
        idle(7);
        commit(32'h8000_0004, 0, 5'd0, 32'h0, 0, 3'd0, 32'h0, 0);
        chk("wd_accept_wins", timeout, 1'b0);
        chk("wd_accept_enable", diff_enable, 1'b1);
        idle(3);
        chk("wd_after", timeout, 1'b0);
`else
        idle(12);
        chk("no_wd_timeout", timeout, 1'b0);
        chk("no_wd_ready", commit_ready, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
